// File: rtl/scan_signature_analyzer.sv
// Scan-out response compactor: folds CHAIN_LEN bits per captured pattern into a SISR and
// compares the final signature with GOLDEN. Optional x_mask input under SCAN_SIGNATURE_XMASK_EN.
module scan_signature_analyzer #(
  parameter int                SIG_W        = 8,
  parameter int                CHAIN_LEN    = 8,
  parameter int                NUM_PATTERNS = 2,
  parameter logic [SIG_W-1:0]  POLY         = 8'h1D,
  parameter logic [SIG_W-1:0]  SEED         = 8'h00,
  parameter logic [SIG_W-1:0]  GOLDEN       = 8'h00
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  scan_en,
  input  logic                                  scan_data,
`ifdef SCAN_SIGNATURE_XMASK_EN
  input  logic                                  x_mask,
`endif
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic [SIG_W-1:0]                      signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_cnt
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic             scan_en_d;
  logic             bit_in;
  logic             window_open;
  logic             accept;
  logic             window_end;
  logic [CW-1:0]    bit_cnt_inc;
  logic [PW-1:0]    pattern_cnt_inc;
  logic [SIG_W-1:0] sig_next;

`ifdef SCAN_SIGNATURE_XMASK_EN
  assign bit_in = scan_data & ~x_mask;
`else
  assign bit_in = scan_data;
`endif

  // First shift cycle after a capture cycle.
  assign window_open     = ~scan_en_d & scan_en;
  assign accept          = ((state == ARMED) & window_open) | ((state == WINDOW) & scan_en);
  // bit_cnt is 0 in ARMED, so the increment covers both the first and later bits.
  assign bit_cnt_inc     = bit_cnt + CW'(1);
  assign window_end      = accept & (bit_cnt_inc == CW'(CHAIN_LEN));
  assign pattern_cnt_inc = pattern_cnt + PW'(1);
  assign sig_next        = {signature[SIG_W-2:0], 1'b0}
                         ^ (signature[SIG_W-1] ? POLY : '0)
                         ^ {{(SIG_W-1){1'b0}}, bit_in};

  assign busy = (state == ARMED) | (state == WINDOW);
  assign done = (state == DONE);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      signature   <= SEED;
      pattern_cnt <= '0;
      bit_cnt     <= '0;
      scan_en_d   <= 1'b1;
      pass        <= 1'b0;
    end else begin
      scan_en_d <= scan_en;
      if (start) begin
        state       <= ARMED;
        signature   <= SEED;
        pattern_cnt <= '0;
        bit_cnt     <= '0;
        pass        <= 1'b0;
      end else if (accept) begin
        signature <= sig_next;
        if (window_end) begin
          bit_cnt     <= '0;
          pattern_cnt <= pattern_cnt_inc;
          if (pattern_cnt_inc == PW'(NUM_PATTERNS)) begin
            state <= DONE;
            pass  <= (sig_next == GOLDEN);
          end else begin
            state <= ARMED;
          end
        end else begin
          bit_cnt <= bit_cnt_inc;
          state   <= WINDOW;
        end
      end else if (state == WINDOW) begin
        // Early capture: keep the compacted bits, drop the window from the count.
        bit_cnt <= '0;
        state   <= ARMED;
      end
    end
  end

endmodule

// File: tb/tb_scan_signature_analyzer.sv
// Randomized bench for scan_signature_analyzer: a transaction-level model (windows of shifted
// bits after each capture) predicts signature, pattern count and pass for two GOLDEN settings.
module tb_scan_signature_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       scan_en;
  logic       scan_data;
  logic       x_mask;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  logic [7:0] sig_a, sig_b;
  logic [1:0] pcnt_a, pcnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_sig;
  int         m_cnt;
  bit         m_done;

  always #5 clk = ~clk;

  // GOLDEN = 8'h00
  scan_signature_analyzer dut_a (
    .clk(clk), .rst(rst), .start(start), .scan_en(scan_en), .scan_data(scan_data),
`ifdef SCAN_SIGNATURE_XMASK_EN
    .x_mask(x_mask),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pattern_cnt(pcnt_a)
  );

  scan_signature_analyzer #(.GOLDEN(8'h26)) dut_b (
    .clk(clk), .rst(rst), .start(start), .scan_en(scan_en), .scan_data(scan_data),
`ifdef SCAN_SIGNATURE_XMASK_EN
    .x_mask(x_mask),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pattern_cnt(pcnt_b)
  );

  // Division step of the bit stream by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] sisr(input logic [7:0] s, input logic b);
    logic [8:0] t;
    t = {s, b};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0];
  endfunction

  task automatic model_start();
    m_sig  = 8'h00;
    m_cnt  = 0;
    m_done = 0;
  endtask

  // A window of len shifted bits: the first 8 are compacted; only full windows count.
  task automatic model_window(input logic [15:0] bits, input int len);
    if (m_done) return;
    for (int i = 0; i < len && i < 8; i++) m_sig = sisr(m_sig, bits[i]);
    if (len >= 8) begin
      m_cnt++;
      if (m_cnt == 2) m_done = 1;
    end
  endtask

  task automatic step(input logic se, input logic sd);
    scan_en   = se;
    scan_data = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1'b1, 1'($urandom));
    start = 1'b0;
    model_start();
  endtask

  task automatic capture(input int n);
    repeat (n) step(1'b0, 1'($urandom));
  endtask

  task automatic run_window(input logic [15:0] bits, input int len, input int cap);
    capture(cap);
    for (int i = 0; i < len; i++) step(1'b1, bits[i]);
    model_window(bits, len);
  endtask

  task automatic check_final(input string tag);
    checks++;
    if (sig_a !== m_sig || sig_b !== m_sig) begin
      errors++;
      $display("FAIL %s signature got %h/%h exp %h", tag, sig_a, sig_b, m_sig);
    end
    checks++;
    if (pcnt_a !== 2'(m_cnt)) begin
      errors++;
      $display("FAIL %s pattern_cnt got %0d exp %0d", tag, pcnt_a, m_cnt);
    end
    checks++;
    if (done_a !== m_done || busy_a !== !m_done) begin
      errors++;
      $display("FAIL %s done/busy got %b/%b exp %b/%b", tag, done_a, busy_a, m_done, !m_done);
    end
    if (m_done) begin
      checks++;
      if (pass_a !== (m_sig == 8'h00) || pass_b !== (m_sig == 8'h26)) begin
        errors++;
        $display("FAIL %s pass got %b/%b exp %b/%b", tag, pass_a, pass_b,
                 m_sig == 8'h00, m_sig == 8'h26);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; scan_en = 1'b1; scan_data = 1'b0; x_mask = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (sig_a !== 8'h00 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got sig=%h busy=%b done=%b pass=%b exp 00/0/0/0",
               sig_a, busy_a, done_a, pass_a);
    end
    // Abort mid-window with an asynchronous reset.
    pulse_start();
    run_window(16'h00FF, 5, 1);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (sig_a !== 8'h00 || busy_a !== 1'b0 || pcnt_a !== 2'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sig=%h busy=%b pcnt=%0d done=%b exp 00/0/0/0",
               sig_a, busy_a, pcnt_a, done_a);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    // Scan activity without start must not disturb the idle analyzer.
    for (int w = 0; w < 3; w++) begin
      capture(1);
      repeat (9) step(1'b1, 1'b1);
    end
    checks++;
    if (sig_a !== 8'h00 || busy_a !== 1'b0 || done_a !== 1'b0 || pcnt_a !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold got sig=%h busy=%b done=%b pcnt=%0d exp 00/0/0/0",
               sig_a, busy_a, done_a, pcnt_a);
    end
  endtask

  task automatic test_all_zero();
    pulse_start();
    run_window(16'h0000, 8, 1);
    run_window(16'h0000, 8, 1);
    checks++;
    if (sig_a !== 8'h00 || pcnt_a !== 2'd2 || done_a !== 1'b1 || pass_a !== 1'b1 || pass_b !== 1'b0) begin
      errors++;
      $display("FAIL all_zero got sig=%h pcnt=%0d done=%b pass=%b/%b exp 00/2/1/1/0",
               sig_a, pcnt_a, done_a, pass_a, pass_b);
    end
  endtask

  task automatic test_single_one();
    pulse_start();
    run_window(16'h0001, 8, 1);
    checks++;
    if (sig_a !== 8'h80 || pcnt_a !== 2'd1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL single_one_w1 got sig=%h pcnt=%0d busy=%b done=%b exp 80/1/1/0",
               sig_a, pcnt_a, busy_a, done_a);
    end
    run_window(16'h0000, 8, 1);
    checks++;
    if (sig_b !== 8'h26 || done_b !== 1'b1 || pass_b !== 1'b1 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL single_one_w2 got sig=%h done=%b pass=%b/%b exp 26/1/1/0",
               sig_b, done_b, pass_b, pass_a);
    end
  endtask

  task automatic test_extra_shifts();
    pulse_start();
    repeat (8) step(1'b1, 1'b1);
    run_window(16'hFF01, 16, 1);
    run_window(16'hFF00, 16, 2);
    checks++;
    if (sig_b !== 8'h26 || done_b !== 1'b1 || pass_b !== 1'b1 || pcnt_b !== 2'd2) begin
      errors++;
      $display("FAIL extra_shifts got sig=%h done=%b pass=%b pcnt=%0d exp 26/1/1/2",
               sig_b, done_b, pass_b, pcnt_b);
    end
  endtask

  task automatic test_early_capture();
    pulse_start();
    run_window(16'h0013, 5, 1);
    capture(1);
    checks++;
    if (pcnt_a !== 2'd0 || busy_a !== 1'b1 || done_a !== 1'b0 || sig_a !== m_sig) begin
      errors++;
      $display("FAIL early_capture got pcnt=%0d busy=%b done=%b sig=%h exp 0/1/0/%h",
               pcnt_a, busy_a, done_a, sig_a, m_sig);
    end
    run_window(16'h00A5, 8, 0);
    checks++;
    if (pcnt_a !== 2'd1 || sig_a !== m_sig || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL after_early got pcnt=%0d sig=%h busy=%b exp 1/%h/1",
               pcnt_a, sig_a, busy_a, m_sig);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    run_window(16'h00FF, 8, 1);
    capture(1);
    repeat (4) step(1'b1, 1'b1);
    pulse_start();
    checks++;
    if (sig_a !== 8'h00 || pcnt_a !== 2'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL restart got sig=%h pcnt=%0d busy=%b done=%b exp 00/0/1/0",
               sig_a, pcnt_a, busy_a, done_a);
    end
    run_window(16'h0001, 8, 1);
    run_window(16'h0000, 8, 1);
    checks++;
    if (sig_b !== 8'h26 || pass_b !== 1'b1 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL restart_rerun got sig=%h pass=%b done=%b exp 26/1/1", sig_b, pass_b, done_b);
    end
  endtask

  task automatic test_random(input int runs);
    for (int r = 0; r < runs; r++) begin
      int extra;
      pulse_start();
      repeat ($urandom_range(0, 10)) step(1'b1, 1'($urandom));
      extra = $urandom_range(0, 1);
      while (!m_done || extra > 0) begin
        int len;
        if (m_done) extra--;
        len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 16);
        run_window(16'($urandom), len, $urandom_range(1, 3));
        check_final($sformatf("random_r%0d", r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_one();
    test_extra_shifts();
    test_early_capture();
    test_restart();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_signature_analyzer.md
Name: scan_signature_analyzer

Overview:
- Output-response compactor that sits directly downstream of the BIST scan chain and consumes its serial scan_out stream.
- Watches scan_en to find capture cycles. After each capture it compacts the next CHAIN_LEN shifted-out bits into a serial-input signature register (SISR).
- After NUM_PATTERNS captured responses it compares the signature with a golden value and reports pass/fail.
- Turns the BIST pattern-generator/scan-chain pair into a self-checking test.

Parameters:
- SIG_W, 8, signature register width (>=4).
- CHAIN_LEN, 8, scan-chain length; bits compacted per captured response.
- NUM_PATTERNS, 2, captured responses compacted per test run.
- POLY, 8'h1D, SISR feedback polynomial taps, SIG_W bits (x^8+x^4+x^3+x^2+1).
- SEED, 8'h00, signature value loaded on start.
- GOLDEN, 8'h00, expected final signature.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new test run.
- scan_en  input  1  same scan_en driving the scan chain; 1=shift, 0=capture.
- scan_data  input  1  serial response; connects to the chain's scan_out.
- busy  output  1  high in ARMED or WINDOW.
- done  output  1  high in DONE; held until next start or rst.
- pass  output  1  valid while done; 1 when signature==GOLDEN.
- signature  output  SIG_W  current SISR contents.
- pattern_cnt  output  clog2(NUM_PATTERNS+1)  responses fully compacted.

Behaviour:
- Reset (async, rst=1): state=IDLE; signature=SEED; pattern_cnt=0; internal bit_cnt=0; scan_en_d=1; busy=0, done=0, pass=0.
- scan_en_d is a one-cycle registered copy of scan_en, updated every cycle in every state.
- A window opens when scan_en_d=0 and scan_en=1, i.e. the first shift cycle after a capture.
- Compaction step, on one accepted bit b: signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{0}}, b}.
- IDLE:
  - start=1 -> signature=SEED, pattern_cnt=0, bit_cnt=0, go to ARMED.
  - Otherwise hold.
- ARMED:
  - Window-open condition -> compact scan_data this cycle, bit_cnt=1, go to WINDOW. If CHAIN_LEN==1, apply the end-of-window rule instead.
  - Otherwise hold.
  - Shift bits before the first capture (initial chain load) are ignored.
- WINDOW:
  - Each cycle with scan_en=1 -> compact, bit_cnt++.
  - On the CHAIN_LEN-th bit: bit_cnt=0, pattern_cnt++. If pattern_cnt reaches NUM_PATTERNS go to DONE, else go to ARMED.
  - scan_en=0 before CHAIN_LEN bits (early capture) -> the partial window is discarded from counting. Bits already compacted stay in signature. bit_cnt=0, go to ARMED.
- Extra shift cycles beyond CHAIN_LEN in the same window are ignored; the next window needs a new capture.
- DONE: done=1, pass=(signature==GOLDEN) registered on DONE entry, signature frozen. start -> re-arm as from IDLE.
- start has priority in every state. It re-initialises signature, counters and pass and goes to ARMED; the window-open condition in that same cycle is ignored.
- Compaction latency: a bit present at posedge N is visible in signature after posedge N.
- done/pass are asserted the cycle after the final bit's posedge.
- rst mid-run aborts immediately to reset values; no partial result is retained.

Optional Feature:
- Macro: SCAN_SIGNATURE_XMASK_EN.
- Defined:
  - Adds input port x_mask (1 bit).
  - When x_mask=1 on an accepted bit, b is forced to 0 before compaction.
  - bit_cnt still advances.
  - Masks unknown/X response bits.
- Undefined: no x_mask port; scan_data is compacted unmodified.

Test Plan:
- Reset and idle: rst=1 mid-run, then rst=0 -> signature=SEED, busy=0, done=0, pass=0. Scan activity without start leaves state unchanged.
- All-zero stream: SEED=0, start, 2 captures each followed by 8 zero bits -> signature=8'h00, pattern_cnt=2, done=1. pass=1 with GOLDEN=8'h00.
- Single-one stream: SEED=0, POLY=8'h1D, GOLDEN=8'h26.
  - Window 1 bits 1,0,0,0,0,0,0,0 -> signature=8'h80 after window 1.
  - Window 2 all zeros -> signature=8'h26, done=1, pass=1.
  - Same stimulus with GOLDEN=8'h27 -> pass=0.
- Extra shifts and pre-capture bits:
  - 16 shift cycles after each capture (bits 9-16 all ones) and 8 ones before the first capture -> signature identical to the 8-bit-window case (8'h26).
- Early capture: scan_en drops after 5 bits of window 1 -> pattern_cnt stays 0, state ARMED. A subsequent full window increments pattern_cnt to 1.
- Restart: start asserted during WINDOW of a run -> signature=SEED, pattern_cnt=0, state ARMED. A subsequent full run reproduces the 8'h26 result.
